cpu_core_mc: RTL and testbench
==============================

// Module: cpu_core_mc
// PURPOSE
// - Parametrised multi-cycle successor to the 8-register CPU: fetch / execute / memory state machine.
// - Adds a configurable data width, register count and address width.
// - Adds a req/ack memory handshake with wait states, a per-register flag bit, branches and HALT.
// - Sits between the system bus and the ALU-level datapath.
// - Instantiates no external ALU; all arithmetic is internal.
// PARAMETERS
// - WIDTH    32  data and register width, in bits (>=16)
// - NREGS    8   number of registers, 2..16; reg r[i] has flag f[i]
// - AW       32  address width, in word addresses
// - RESET_PC 0   PC value loaded on reset
// PORTS
// - clock      in   1      rising-edge clock
// - reset      in   1      synchronous, active-high
// - mem_addr   out  AW     bus word address
// - mem_wdata  out  WIDTH  store data
// - mem_rdata  in   WIDTH  fetch/load data, valid with mem_ack
// - mem_req    out  1      bus request; held high until mem_ack
// - mem_we     out  1      1 = store, 0 = read; valid while mem_req
// - mem_ack    in   1      transfer complete this cycle
// - halted     out  1      core in HALT state
// - trap       out  1      illegal opcode seen (CPU_TRAP_EN only, else tied 0)
// - pc_out     out  AW     current PC (debug)
// BEHAVIOUR
// Reset:
// - pc=RESET_PC; all regs and flags 0; state=FETCH.
// - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, trap=0.
// - Reset mid-transaction aborts it: mem_req is 0 on the cycle after reset is sampled. The bus must tolerate the abort.
// Instruction format (32 bits):
// - op[6:0], ra[10:7], rb[14:11], rd[18:15], imm[31:19] (13-bit signed, sign-extended to WIDTH/AW).
// - Register index >= NREGS: reads return 0, writes are dropped.
// States:
// - FETCH: mem_req=1, mem_we=0, mem_addr=pc.
//   - On mem_ack: ir<=mem_rdata[31:0], pc<=pc+1 (wraps mod 2^AW), -> EXEC.
//   - No ack: hold all bus outputs stable.
// - EXEC: one cycle, using the fetched opcode:
//   - 0 NOP: no effect.
//   - 1 ADD: r[rd]=ra+rb, f[rd]=carry.
//   - 2 SUB: r[rd]=ra-rb, f[rd]=borrow.
//   - 3 AND, 4 OR, 5 XOR: r[rd]=result, f[rd]=(result==0).
//   - 6 LDI: r[rd]=sext(imm), f[rd] unchanged.
//   - 7 ST: -> MEM with we=1, addr=r[rb][AW-1:0], wdata=r[ra].
//   - 8 LD: -> MEM with we=0, addr=r[ra][AW-1:0].
//   - 9 BRF: if f[ra] then pc=pc+sext(imm); pc is already incremented, so the offset is relative to the next instruction.
//   - 10 JMP: pc=r[ra][AW-1:0].
//   - 11 HALT: -> HALT.
//   - 12..127: illegal (see CONFIGURATION).
//   - All ops except LD/ST/HALT return to FETCH.
// - MEM: mem_req=1 until mem_ack.
//   - On ack, LD writes r[rd]=mem_rdata; f[rd] unchanged.
//   - -> FETCH.
// - HALT: halted=1, mem_req=0; only reset leaves HALT.
// Timing and bus rules:
// - mem_req deasserts on the cycle after an ack. Minimum CPI: 2 for ALU/branch, 4 for LD/ST, with zero-wait ack.
// - Write-back occurs at the clock edge ending EXEC or MEM. A same-register read in the next instruction sees the new value.
// - rd==ra/rb is legal; operands are read before the write.
// - ack while mem_req=0 is ignored.
// CONFIGURATION
// - CPU_TRAP_EN defined: illegal opcode -> HALT with trap=1 and halted=1; pc_out points past the bad instruction.
// - CPU_TRAP_EN undefined: illegal opcode executes as NOP; trap tied 0.
// TESTING
// 1. Reset then LDI r1,5; LDI r2,-3; ADD r3,r1,r2; HALT, zero-wait ack -> r3=2, f3=1, halted after 9 cycles.
// 2. Same program with ack delayed 3 cycles -> mem_req/addr stable while waiting, identical register results.
// 3. ST r1->[r2=0x40] then LD r4<-[0x40] -> bus sees we=1 addr 0x40 data 5, then r4=5.
// 4. SUB r1,r1,r1 (r1=0) sets f1=0; BRF r1,+2 not taken; ADD with carry-out sets f; BRF taken -> pc=pc+1+2.
// 5. Assert reset while MEM waits for ack -> next cycle mem_req=0, pc=RESET_PC, regs 0.
// 6. Opcode 0x7F -> with CPU_TRAP_EN: trap=1, halted=1; without: NOP, next fetch at pc+1.

Source files
------------

// File: rtl/cpu_core_mc_if.sv
// rtl/cpu_core_mc_if.sv - req/ack memory bus between cpu_core_mc and the system bus
interface cpu_core_mc_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 32
) ();
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_req;
    logic             mem_we;
    logic             mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_req, mem_we,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_req, mem_we,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cpu_core_mc.sv
// rtl/cpu_core_mc.sv - multi-cycle fetch/exec/mem CPU core with req/ack bus
// Define CPU_TRAP_EN to halt with trap=1 on illegal opcodes; otherwise they execute as NOP.
module cpu_core_mc #(
    parameter int              WIDTH    = 32,
    parameter int              NREGS    = 8,
    parameter int              AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clock,
    input  logic          reset,
    cpu_core_mc_if.master bus,
    output logic          halted,
    output logic          trap,
    output logic [AW-1:0] pc_out
);
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
    state_t state, state_n;

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] flags;
    logic [31:0]      ir, ir_n;
    logic [AW-1:0]    pc, pc_n;
    logic [AW-1:0]    addr_q, addr_n;
    logic [WIDTH-1:0] wdata_q, wdata_n;
    logic             req_q, req_n, we_q, we_n, trap_q, trap_n;

    logic             wb_en, wb_flag_en, wb_flag;
    logic [WIDTH-1:0] wb_val;

    logic [6:0]       op;
    logic [3:0]       ra, rb, rd;
    logic [12:0]      imm;
    logic [WIDTH-1:0] va, vb, imm_w, logic_res;
    logic [AW-1:0]    imm_a;
    logic [WIDTH:0]   sum, diff;
    logic             fa;

    assign op    = ir[6:0];
    assign ra    = ir[10:7];
    assign rb    = ir[14:11];
    assign rd    = ir[18:15];
    assign imm   = ir[31:19];
    assign imm_w = WIDTH'($signed(imm));
    assign imm_a = AW'($signed(imm));

    // Indices past the implemented register file read as zero.
    assign va = (int'(ra) < NREGS) ? regs[ra[IW-1:0]] : '0;
    assign vb = (int'(rb) < NREGS) ? regs[rb[IW-1:0]] : '0;
    assign fa = (int'(ra) < NREGS) ? flags[ra[IW-1:0]] : 1'b0;

    assign sum  = {1'b0, va} + {1'b0, vb};
    assign diff = {1'b0, va} - {1'b0, vb};

    always_comb begin
        case (op)
            7'd3:    logic_res = va & vb;
            7'd4:    logic_res = va | vb;
            default: logic_res = va ^ vb;
        endcase
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        req_n      = req_q;
        we_n       = we_q;
        trap_n     = trap_q;
        wb_en      = 1'b0;
        wb_val     = '0;
        wb_flag_en = 1'b0;
        wb_flag    = 1'b0;

        unique case (state)
            S_FETCH: begin
                // req starts low after reset or a data transfer, so the first cycle only launches the fetch.
                if (!req_q) begin
                    req_n  = 1'b1;
                    we_n   = 1'b0;
                    addr_n = pc;
                end else if (bus.mem_ack) begin
                    ir_n    = 32'(bus.mem_rdata);
                    pc_n    = pc + AW'(1);
                    req_n   = 1'b0;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                state_n = S_FETCH;
                case (op)
                    7'd0: begin end
                    7'd1: begin
                        wb_en = 1'b1; wb_val = sum[WIDTH-1:0];
                        wb_flag_en = 1'b1; wb_flag = sum[WIDTH];
                    end
                    7'd2: begin
                        wb_en = 1'b1; wb_val = diff[WIDTH-1:0];
                        wb_flag_en = 1'b1; wb_flag = diff[WIDTH];
                    end
                    7'd3, 7'd4, 7'd5: begin
                        wb_en = 1'b1; wb_val = logic_res;
                        wb_flag_en = 1'b1; wb_flag = (logic_res == '0);
                    end
                    7'd6: begin
                        wb_en = 1'b1; wb_val = imm_w;
                    end
                    7'd7: begin
                        req_n = 1'b1; we_n = 1'b1;
                        addr_n = AW'(vb); wdata_n = va;
                        state_n = S_MEM;
                    end
                    7'd8: begin
                        req_n = 1'b1; we_n = 1'b0;
                        addr_n = AW'(va);
                        state_n = S_MEM;
                    end
                    7'd9:  if (fa) pc_n = pc + imm_a;
                    7'd10: pc_n = AW'(va);
                    7'd11: state_n = S_HALT;
                    default: begin
`ifdef CPU_TRAP_EN
                        trap_n  = 1'b1;
                        state_n = S_HALT;
`else
                        state_n = S_FETCH;
`endif
                    end
                endcase
                // Launch the next fetch straight from EXEC to keep ALU/branch CPI at 2.
                if (state_n == S_FETCH) begin
                    req_n  = 1'b1;
                    we_n   = 1'b0;
                    addr_n = pc_n;
                end
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    req_n   = 1'b0;
                    state_n = S_FETCH;
                    if (!we_q) begin
                        wb_en  = 1'b1;
                        wb_val = bus.mem_rdata;
                    end
                end
            end
            S_HALT: begin end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            trap_q  <= 1'b0;
            flags   <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            ir      <= ir_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            req_q   <= req_n;
            we_q    <= we_n;
            trap_q  <= trap_n;
            if (wb_en && int'(rd) < NREGS) regs[rd[IW-1:0]] <= wb_val;
            if (wb_flag_en && int'(rd) < NREGS) flags[rd[IW-1:0]] <= wb_flag;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign halted        = (state == S_HALT);
    assign trap          = trap_q;
    assign pc_out        = pc;
endmodule

// File: tb/tb_cpu_core_mc.sv
// tb/tb_cpu_core_mc.sv - self-checking bench for cpu_core_mc against an instruction-level model
`timescale 1ns/1ps
module tb_cpu_core_mc;
    localparam int WIDTH  = 32;
    localparam int NREGS  = 8;
    localparam int AW     = 32;
    localparam int MAXI   = 400;
    localparam int BUDGET = 3000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          halted, trap;
    logic [AW-1:0] pc_out;

    cpu_core_mc_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    cpu_core_mc #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .RESET_PC(32'h0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .halted(halted),
        .trap  (trap),
        .pc_out(pc_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        expq[$];
    logic [31:0] prog[$];
    logic [31:0] mem_d[256];
    logic [31:0] mm[256];
    logic [31:0] mr[NREGS];
    bit          mf[NREGS];
    logic [31:0] mpc;
    bit          m_halt, m_trap;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int ra, input int rb, input int rd, input int imm);
        return {imm[12:0], rd[3:0], rb[3:0], ra[3:0], op[6:0]};
    endfunction

    function automatic logic [31:0] rv(input int i);
        return (i < NREGS) ? mr[i] : 32'h0;
    endfunction

    task automatic wr(input int i, input logic [31:0] v);
        if (i < NREGS) mr[i] = v;
    endtask

    task automatic wf(input int i, input bit v);
        if (i < NREGS) mf[i] = v;
    endtask

    // Instruction-set interpreter: yields the expected bus transfers in order.
    task automatic model_run();
        logic [31:0] inst, a, b, res;
        logic [63:0] s;
        int          op, ra, rb, rd, simm;
        expq.delete();
        m_halt = 0; m_trap = 0; mpc = 32'h0;
        foreach (mr[i]) begin mr[i] = 32'h0; mf[i] = 0; end
        for (int n = 0; n < MAXI && !m_halt; n++) begin
            expq.push_back('{1'b0, mpc, 32'h0});
            inst = mm[mpc[7:0]];
            mpc  = mpc + 32'd1;
            op   = int'(inst & 32'h7f);
            ra   = int'((inst >> 7) & 32'hf);
            rb   = int'((inst >> 11) & 32'hf);
            rd   = int'((inst >> 15) & 32'hf);
            simm = int'(inst >> 19);
            if (simm >= 4096) simm -= 8192;
            a = rv(ra);
            b = rv(rb);
            case (op)
                0: begin end
                1: begin s = 64'(a) + 64'(b); wr(rd, s[31:0]); wf(rd, s > 64'hFFFF_FFFF); end
                2: begin wr(rd, a - b); wf(rd, a < b); end
                3: begin res = a & b; wr(rd, res); wf(rd, res == 0); end
                4: begin res = a | b; wr(rd, res); wf(rd, res == 0); end
                5: begin res = a ^ b; wr(rd, res); wf(rd, res == 0); end
                6: wr(rd, 32'(simm));
                7: begin expq.push_back('{1'b1, b, a}); mm[b[7:0]] = a; end
                8: begin expq.push_back('{1'b0, a, 32'h0}); wr(rd, mm[a[7:0]]); end
                9: if (ra < NREGS && mf[ra]) mpc = mpc + 32'(simm);
                10: mpc = a;
                11: m_halt = 1;
                default: begin
`ifdef CPU_TRAP_EN
                    m_halt = 1;
                    m_trap = 1;
`endif
                end
            endcase
        end
    endtask

    task automatic load_prog();
        foreach (mm[i]) mm[i] = enc(11, 0, 0, 0, 0);
        foreach (prog[i]) mm[i] = prog[i];
        mem_d = mm;
        model_run();
    endtask

    task automatic do_reset(input bit check);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        if (check) begin
            chk("rst_req", bus.mem_req, 0);
            chk("rst_we", bus.mem_we, 0);
            chk("rst_addr", bus.mem_addr, 0);
            chk("rst_wdata", bus.mem_wdata, 0);
            chk("rst_halted", halted, 0);
            chk("rst_trap", trap, 0);
            chk("rst_pc", pc_out, 0);
        end
        reset = 1'b0;
    endtask

    // Acts as the memory: random wait states, spurious acks while idle, bus-stability checks.
    task automatic run_dut(input int max_wait, input bit fixed, output int halt_cyc);
        int          idx, waitc, target, cyc;
        bit          pending, acked, pwe;
        logic [31:0] paddr, pwdata;
        idx = 0; waitc = 0; cyc = 0; pending = 0; acked = 0;
        pwe = 0; paddr = 0; pwdata = 0;
        target = fixed ? max_wait : int'($urandom_range(max_wait, 0));
        halt_cyc = -1;
        while (cyc < BUDGET) begin
            @(negedge clock);
            cyc++;
            if (halted) begin
                halt_cyc = cyc;
                break;
            end
            if (acked) chk("req_drop", bus.mem_req, 0);
            if (pending) begin
                chk("hold_req", bus.mem_req, 1);
                chk("hold_addr", bus.mem_addr, paddr);
                chk("hold_we", bus.mem_we, pwe);
                if (pwe) chk("hold_wdata", bus.mem_wdata, pwdata);
            end
            acked = 0; pending = 0;
            if (bus.mem_req) begin
                if (waitc < target) begin
                    bus.mem_ack = 1'b0;
                    waitc++;
                    pending = 1;
                    paddr = bus.mem_addr; pwe = bus.mem_we; pwdata = bus.mem_wdata;
                end else begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_d[bus.mem_addr[7:0]];
                    if (idx < expq.size()) begin
                        chk("txn_we", bus.mem_we, expq[idx].we);
                        chk("txn_addr", bus.mem_addr, expq[idx].addr);
                        if (expq[idx].we) chk("txn_wdata", bus.mem_wdata, expq[idx].data);
                    end else begin
                        chk("txn_extra", idx, expq.size());
                    end
                    if (bus.mem_we) mem_d[bus.mem_addr[7:0]] = bus.mem_wdata;
                    idx++;
                    waitc = 0;
                    acked = 1;
                    target = fixed ? max_wait : int'($urandom_range(max_wait, 0));
                end
            end else begin
                bus.mem_ack   = ($urandom_range(3, 0) == 0);
                bus.mem_rdata = $urandom();
            end
        end
        bus.mem_ack = 1'b0;
        chk("txn_count", idx, expq.size());
        chk("halted", halted, m_halt);
        chk("trap", trap, m_trap);
        chk("pc_out", pc_out, mpc);
    endtask

    task automatic gen_random();
        int k, op, imm;
        prog.delete();
        for (int i = 0; i < 24; i++) begin
            k = int'($urandom_range(11, 0));
            op = (k == 10) ? 127 : (k == 11) ? 0 : k;
            imm = (op == 9) ? int'($urandom_range(3, 0)) : int'($urandom_range(8191, 0));
            prog.push_back(enc(op, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                               int'($urandom_range(15, 0)), imm));
        end
        prog.push_back(enc(11, 0, 0, 0, 0));
    endtask

    initial begin
        int hc, tries;
        bit seen;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        // LDI/LDI/ADD/HALT with zero-wait ack: HALT entered on the 9th edge after reset.
        prog = '{enc(6, 0, 0, 1, 5), enc(6, 0, 0, 2, -3), enc(1, 1, 2, 3, 0), enc(11, 0, 0, 0, 0)};
        load_prog();
        do_reset(1);
        run_dut(0, 1, hc);
        chk("t1_halt_cycle", hc, 9);

        // Same arithmetic with 3 wait states; result and carry flag observed through stores.
        prog = '{enc(6, 0, 0, 1, 5), enc(6, 0, 0, 2, -3), enc(1, 1, 2, 3, 0), enc(9, 3, 0, 0, 1),
                 enc(7, 3, 0, 0, 0), enc(7, 3, 1, 0, 0), enc(11, 0, 0, 0, 0)};
        load_prog();
        do_reset(0);
        run_dut(3, 1, hc);

        // Store/load round trip through 0x40, plus a read of an unimplemented register.
        prog = '{enc(6, 0, 0, 1, 5), enc(6, 0, 0, 2, 32'h40), enc(7, 1, 2, 0, 0), enc(8, 2, 0, 4, 0),
                 enc(7, 4, 0, 0, 0), enc(6, 0, 0, 9, 3), enc(7, 9, 0, 0, 0), enc(11, 0, 0, 0, 0)};
        load_prog();
        do_reset(0);
        run_dut(2, 0, hc);

        // Flags: SUB clears, BRF not taken; ADD carry sets, BRF taken; then JMP.
        prog = '{enc(6, 0, 0, 1, 9), enc(2, 1, 1, 1, 0), enc(9, 1, 0, 0, 2), enc(7, 1, 0, 0, 0),
                 enc(0, 0, 0, 0, 0), enc(6, 0, 0, 2, -1), enc(1, 2, 2, 3, 0), enc(9, 3, 0, 0, 2),
                 enc(7, 2, 0, 0, 0), enc(0, 0, 0, 0, 0), enc(7, 3, 0, 0, 0), enc(6, 0, 0, 6, 30),
                 enc(10, 6, 0, 0, 0), enc(11, 0, 0, 0, 0)};
        load_prog();
        do_reset(0);
        run_dut(1, 0, hc);

        // Illegal opcode 0x7F.
        prog = '{enc(6, 0, 0, 1, 7), 32'h0000_007F, enc(7, 1, 0, 0, 0), enc(11, 0, 0, 0, 0)};
        load_prog();
        do_reset(0);
        run_dut(1, 0, hc);

        // Reset while a load waits for ack.
        prog = '{enc(6, 0, 0, 1, -1), enc(1, 1, 1, 5, 0), enc(6, 0, 0, 2, 32'h40), enc(8, 2, 0, 4, 0)};
        load_prog();
        do_reset(0);
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clock);
            if (bus.mem_req && bus.mem_addr == 32'h40) seen = 1;
            else begin
                bus.mem_ack   = bus.mem_req;
                bus.mem_rdata = mem_d[bus.mem_addr[7:0]];
            end
        end
        bus.mem_ack = 1'b0;
        chk("t5_load_seen", seen, 1);
        @(negedge clock);
        chk("t5_stall_req", bus.mem_req, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("t5_abort_req", bus.mem_req, 0);
        chk("t5_abort_pc", pc_out, 0);
        chk("t5_abort_halted", halted, 0);
        // Registers and flags must now be zero: BRF r5 not taken, stores carry zeros.
        prog = '{enc(9, 5, 0, 0, 1), enc(7, 5, 0, 0, 0), enc(7, 1, 0, 0, 0), enc(7, 4, 2, 0, 0),
                 enc(11, 0, 0, 0, 0)};
        load_prog();
        reset = 1'b0;
        run_dut(2, 0, hc);

        for (int t = 0; t < 20; t++) begin
            tries = 0;
            do begin
                gen_random();
                load_prog();
                tries++;
            end while (!m_halt && tries < 20);
            do_reset(0);
            run_dut(3, 0, hc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
